// File: rtl/gray_code_converter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_code_converter
//  Description : Parameterised binary/Gray code converter.
//                - o_gray is a purely combinational binary->Gray view of
//                  i_binary.
//                - A registered path converts i_data in either direction,
//                  selected per sample by i_mode. It has a latency of one
//                  cycle and is qualified by i_valid.
//                - A step monitor flags samples whose Gray-domain value
//                  differs from the previous accepted one in exactly one bit.
//  Ports       : i_clk     - clock, rising edge active
//                i_rstn    - asynchronous active-low reset
//                i_binary  - operand for the combinational path
//                o_gray    - Gray code of i_binary (combinational)
//                i_valid   - qualifies i_mode / i_data
//                i_mode    - 0 = binary->Gray, 1 = Gray->binary
//                i_data    - operand for the registered path
//                o_valid   - registered result valid
//                o_data    - registered conversion result
//                o_step1   - single-bit Gray step detected on this sample
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_code_converter #(
    parameter int BW_DATA = 3
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [BW_DATA-1:0] i_binary,
    output logic [BW_DATA-1:0] o_gray,
    input  logic               i_valid,
    input  logic               i_mode,
    input  logic [BW_DATA-1:0] i_data,
    output logic               o_valid,
    output logic [BW_DATA-1:0] o_data,
    output logic               o_step1
);

    localparam logic [BW_DATA-1:0] c_ONE = BW_DATA'(1);

    logic [BW_DATA-1:0] w_b2g;        // i_data interpreted as binary -> Gray
    logic [BW_DATA-1:0] w_g2b;        // i_data interpreted as Gray -> binary
    logic [BW_DATA-1:0] w_conv;       // result selected by i_mode
    logic [BW_DATA-1:0] w_gray_val;   // Gray-domain value of this sample
    logic [BW_DATA-1:0] w_diff;
    logic               w_one_bit;

    logic               r_valid;
    logic [BW_DATA-1:0] r_data;
    logic               r_step1;
    logic [BW_DATA-1:0] r_prev_gray;
    logic               r_prev_ok;

    // Combinational path: no clock or reset involvement.
    assign o_gray = i_binary ^ (i_binary >> 1);

    assign w_b2g  = i_data ^ (i_data >> 1);

    // Gray->binary is a running XOR from the MSB downwards: each binary bit
    // is the parity of all Gray bits at or above its position.
    always_comb begin
        w_g2b = '0;
        w_g2b[BW_DATA-1] = i_data[BW_DATA-1];
        for (int k = BW_DATA - 2; k >= 0; k--) begin
            w_g2b[k] = w_g2b[k+1] ^ i_data[k];
        end
    end

    assign w_conv     = i_mode ? w_g2b : w_b2g;
    // In Gray->binary mode the operand itself is already the Gray value.
    assign w_gray_val = i_mode ? i_data : w_b2g;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign w_diff    = w_gray_val ^ r_prev_gray;
    assign w_one_bit = (w_diff != '0) && ((w_diff & (w_diff - c_ONE)) == '0);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_step1     <= 1'b0;
            r_prev_gray <= '0;
            r_prev_ok   <= 1'b0;
        end else if (i_valid) begin
            r_valid     <= 1'b1;
            r_data      <= w_conv;
            r_step1     <= r_prev_ok && w_one_bit;
            r_prev_gray <= w_gray_val;
            r_prev_ok   <= 1'b1;
        end else begin
            // Idle cycle: result data and monitor history are retained.
            r_valid     <= 1'b0;
            r_step1     <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_step1 = r_step1;

endmodule
`default_nettype wire

// File: tb/tb_gray_code_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_code_converter
//  Description : Self-checking bench for gray_code_converter (BW_DATA = 3),
//                using a behavioural reference model and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_code_converter;

    localparam int BW = 3;

    logic          i_clk;
    logic          i_rstn;
    logic [BW-1:0] i_binary;
    logic [BW-1:0] o_gray;
    logic          i_valid;
    logic          i_mode;
    logic [BW-1:0] i_data;
    logic          o_valid;
    logic [BW-1:0] o_data;
    logic          o_step1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [BW-1:0] m_prev;
    logic          m_ok;
    logic          m_valid;
    logic [BW-1:0] m_data;
    logic          m_step;

    gray_code_converter #(.BW_DATA(BW)) u_dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_binary (i_binary),
        .o_gray   (o_gray),
        .i_valid  (i_valid),
        .i_mode   (i_mode),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_step1  (o_step1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] to_gray(input logic [BW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Inverse defined by search: the binary value whose Gray code is g.
    function automatic logic [BW-1:0] from_gray(input logic [BW-1:0] g);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < (1 << BW); i++) begin
            if (to_gray(BW'(i)) == g) r = BW'(i);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_prev  = '0;
        m_ok    = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_step  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
        check_val({tag, ".data"},  32'(o_data),  32'(m_data));
        check_val({tag, ".step1"}, 32'(o_step1), 32'(m_step));
    endtask

    // Apply one cycle of stimulus, advance the model, compare after the edge.
    task automatic step(input logic v, input logic m, input logic [BW-1:0] d, input string tag);
        logic [BW-1:0] g;
        i_valid = v;
        i_mode  = m;
        i_data  = d;
        @(posedge i_clk);
        #1;
        if (v) begin
            g       = m ? d : to_gray(d);
            m_step  = m_ok && ($countones(g ^ m_prev) == 1);
            m_data  = m ? from_gray(d) : to_gray(d);
            m_valid = 1'b1;
            m_prev  = g;
            m_ok    = 1'b1;
        end else begin
            m_valid = 1'b0;
            m_step  = 1'b0;
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [BW-1:0] gray_tbl [8];
        logic [BW-1:0] r;
        gray_tbl = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

        i_rstn   = 1'b0;
        i_binary = '0;
        i_valid  = 1'b0;
        i_mode   = 1'b0;
        i_data   = '0;
        model_reset();
        #2;
        check_outputs("reset");

        // Combinational sweep and random vectors
        for (int i = 0; i < 8; i++) begin
            i_binary = BW'(i);
            #1;
            check_val("comb_sweep", 32'(o_gray), 32'(gray_tbl[i]));
        end
        for (int i = 0; i < 100; i++) begin
            r = BW'($urandom);
            i_binary = r;
            #10;
            check_val("comb_rand", 32'(o_gray), 32'(r ^ (r >> 1)));
        end

        @(negedge i_clk);
        i_rstn = 1'b1;

        // Mode 0: 5 -> 7 (first sample), 6 -> 5 (single-bit step)
        step(1'b1, 1'b0, 3'd5, "m0_5");
        check_val("m0_5_const", 32'(o_data), 32'd7);
        step(1'b1, 1'b0, 3'd6, "m0_6");
        check_val("m0_6_const", 32'(o_data), 32'd5);
        check_val("m0_6_step", 32'(o_step1), 32'd1);

        // Mode 1 directed
        step(1'b1, 1'b1, 3'd4, "m1_4");
        check_val("m1_4_const", 32'(o_data), 32'd7);
        step(1'b1, 1'b1, 3'd6, "m1_6");
        check_val("m1_6_const", 32'(o_data), 32'd4);
        step(1'b1, 1'b1, 3'd0, "m1_0");
        check_val("m1_0_const", 32'(o_data), 32'd0);

        // Mode 1 full sweep (inverse of the combinational path)
        for (int g = 0; g < 8; g++) step(1'b1, 1'b1, BW'(g), "m1_sweep");

        // Step monitor cases
        step(1'b1, 1'b0, 3'd7, "wrap_7");
        step(1'b1, 1'b0, 3'd0, "wrap_0");
        check_val("wrap_step", 32'(o_step1), 32'd1);
        step(1'b1, 1'b0, 3'd1, "s12_1");
        step(1'b1, 1'b0, 3'd2, "s12_2");
        check_val("s12_step", 32'(o_step1), 32'd1);
        step(1'b1, 1'b0, 3'd0, "s02_0");
        step(1'b1, 1'b0, 3'd2, "s02_2");
        check_val("s02_step", 32'(o_step1), 32'd0);
        step(1'b1, 1'b0, 3'd3, "rep_3a");
        step(1'b1, 1'b0, 3'd3, "rep_3b");
        check_val("rep_step", 32'(o_step1), 32'd0);

        // Valid gating: two idle cycles, then compare against last accepted
        step(1'b0, 1'b0, 3'd6, "gap1");
        step(1'b0, 1'b1, 3'd1, "gap2");
        check_val("gap_hold", 32'(o_data), 32'd2);
        step(1'b1, 1'b0, 3'd2, "after_gap");
        check_val("after_gap_step", 32'(o_step1), 32'd1);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(3) != 0), 1'($urandom), BW'($urandom), "rand");
        end

        // Asynchronous reset between edges while o_valid is high
        step(1'b1, 1'b0, 3'd5, "pre_rst");
        #3;
        i_rstn = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge i_clk);
        i_rstn = 1'b1;
        step(1'b1, 1'b0, 3'd1, "post_rst");
        check_val("post_rst_step", 32'(o_step1), 32'd0);
        step(1'b1, 1'b0, 3'd3, "post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_code_converter.md
Name:
gray_code_converter

Overview:
- Parameterised binary/Gray code converter.
- Provides an always-present combinational binary-to-Gray output.
- Provides a registered, mode-selectable conversion path (binary->Gray or Gray->binary) with valid qualification and a single-bit-step monitor.
- Used as a leaf utility block wherever counters or pointers cross between binary and Gray encodings, e.g. FIFO pointers or encoder sampling.

Parameters:
- BW_DATA, default 3, data width in bits; legal range 1..32.

Ports:
- i_clk  input  1  system clock; rising edge active.
- i_rstn  input  1  asynchronous active-low reset.
- i_binary  input  BW_DATA  binary operand for the combinational path.
- o_gray  output  BW_DATA  combinational Gray code of i_binary.
- i_valid  input  1  qualifies i_data/i_mode for the registered path.
- i_mode  input  1  registered-path mode: 0 = binary->Gray, 1 = Gray->binary.
- i_data  input  BW_DATA  operand for the registered path.
- o_valid  output  1  registered result valid.
- o_data  output  BW_DATA  registered conversion result.
- o_step1  output  1  high when the current Gray-domain value differs from the previous valid one in exactly one bit.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low: i_rstn low immediately forces all registers to 0.
- Combinational path:
  - o_gray = i_binary XOR (i_binary >> 1).
  - Pure combinational; no clock or reset dependence; valid in the same delta as i_binary changes.
- Binary->Gray (mode 0): g[MSB] = b[MSB]; g[k] = b[k+1] XOR b[k].
- Gray->binary (mode 1): b[MSB] = g[MSB]; b[k] = b[k+1] XOR g[k], evaluated MSB to LSB.
- Registered path, latency 1 cycle:
  - On a rising edge with i_valid=1: o_data <= conversion of i_data per i_mode, and o_valid <= 1.
  - On a rising edge with i_valid=0: o_valid <= 0 and o_data holds its last value.
- Step monitor:
  - Internal register prev_gray (BW_DATA) plus flag prev_ok.
  - The Gray-domain value of an accepted sample is its converted output in mode 0, or i_data itself in mode 1.
  - On each accepted sample: o_step1 <= prev_ok AND (popcount(gray_value XOR prev_gray) == 1); then prev_gray <= gray_value and prev_ok <= 1.
  - On cycles with i_valid=0: o_step1 <= 0; prev_gray and prev_ok hold.
  - The first valid sample after reset always gives o_step1=0.
  - A repeated identical value gives o_step1=0 (zero bits differ).
- Reset values: o_valid=0, o_data=0, o_step1=0, prev_gray=0, prev_ok=0.
- Reset mid-operation:
  - Outputs clear asynchronously.
  - The first edge after reset release behaves as a first sample.
- Mode may change on any valid cycle; each sample is converted independently, with no state carried across samples except the step monitor.
- Wrap-around: binary max (2^BW-1) to 0 maps to Gray 100..0 to 000..0, a one-bit step, so o_step1=1.
- No X propagation: with inputs known, all outputs are known after reset.

Test Plan:
- Combinational sweep, BW_DATA=3: i_binary 0..7 -> o_gray 0,1,3,2,6,7,5,4. Also apply 100 random vectors spaced 10 ns; check o_gray == b^(b>>1) for each.
- Registered mode 0:
  - After reset release, drive i_valid=1 with i_data 5 then 6.
  - Next cycles give o_data=7 (o_step1=0, first sample), then o_data=5 (o_step1=1).
- Registered mode 1:
  - i_data Gray 4 -> o_data 7; Gray 6 -> o_data 4; Gray 0 -> o_data 0; o_valid=1 one cycle later each time.
  - A full sweep shows gray->binary is the exact inverse of the combinational path.
- Step monitor:
  - Mode 0 binary sequence 7,0 gives o_step1=1 on the 0 (wrap).
  - Binary 1 then 2 (Gray 1 -> 3) gives 1.
  - Binary 0 then 2 (Gray 0 -> 3) gives 0.
  - Repeated 3,3 gives 0.
- Valid gating: deassert i_valid for 2 cycles. Required: o_valid=0, o_step1=0, o_data held. The next valid sample compares against the last accepted value.
- Asynchronous reset: assert i_rstn=0 between clock edges while o_valid=1. Required: o_valid, o_data and o_step1 go to 0 immediately. The first valid sample after release gives o_step1=0.
